uart_fifo_sync: RTL

UART_FIFO_SYNC -- requirements
Module: uart_fifo_sync

---
 rtl/uart_fifo_sync.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO with registered read data, occupancy count and status flags.
// Optional sticky overflow/underflow flags enabled by defining UART_FIFO_SYNC_ERR_EN.
module uart_fifo_sync #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  i_fifo_clk,
  input  logic                  i_fifo_rst,
  input  logic                  i_fifo_winc,
  input  logic [DATA_WIDTH-1:0] i_fifo_wdata,
  input  logic                  i_fifo_rinc,
  input  logic                  i_fifo_err_clr,
  output logic [DATA_WIDTH-1:0] o_fifo_rdata,
  output logic                  o_fifo_rvalid,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_afull,
  output logic                  o_fifo_aempty,
  output logic [ADDR_WIDTH:0]   o_fifo_count,
  output logic                  o_fifo_ovf,
  output logic                  o_fifo_udf
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [PTR_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full_c, empty_c, wr_acc_c, rd_acc_c;

  // Equal address bits with differing wrap bits means full.
  assign full_c  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                   (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
  assign empty_c = (wptr_q == rptr_q);

  assign rd_acc_c = i_fifo_rinc && !empty_c;
  assign wr_acc_c = i_fifo_winc && (!full_c || rd_acc_c);

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;

    if (wr_acc_c) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (rd_acc_c) begin
      rptr_d   = rptr_q + PTR_W'(1);
      rdata_d  = mem_q[rptr_q[ADDR_WIDTH-1:0]];
      rvalid_d = 1'b1;
    end

    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase

`ifdef UART_FIFO_SYNC_ERR_EN
    // A rejection in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (i_fifo_err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (i_fifo_winc && !wr_acc_c) ovf_d = 1'b1;
    if (i_fifo_rinc && !rd_acc_c) udf_d = 1'b1;
`endif
  end

`ifndef UART_FIFO_SYNC_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = i_fifo_err_clr ^ ovf_q ^ udf_q;
`endif

  always_ff @(posedge i_fifo_clk) begin
    if (i_fifo_rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; reset only blocks a same-cycle write.
  always_ff @(posedge i_fifo_clk) begin
    if (!i_fifo_rst && wr_acc_c) begin
      mem_q[wptr_q[ADDR_WIDTH-1:0]] <= i_fifo_wdata;
    end
  end

  assign o_fifo_rdata  = rdata_q;
  assign o_fifo_rvalid = rvalid_q;
  assign o_fifo_full   = full_c;
  assign o_fifo_empty  = empty_c;
  assign o_fifo_afull  = (count_q >= PTR_W'(AFULL_THRESH));
  assign o_fifo_aempty = (count_q <= PTR_W'(AEMPTY_THRESH));
  assign o_fifo_count  = count_q;
`ifdef UART_FIFO_SYNC_ERR_EN
  assign o_fifo_ovf    = ovf_q;
  assign o_fifo_udf    = udf_q;
`else
  assign o_fifo_ovf    = 1'b0;
  assign o_fifo_udf    = 1'b0;
`endif

endmodule
